// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch/decode types and opcode constants
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int OPCODE_W = 4;

    // The decoder compares against the same constant, so both stay in step.
    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with reset > load > increment priority
module pc_reg #(
    parameter int                   BUS_WIDTH    = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] target,
    input  logic                 inc,
    output logic [BUS_WIDTH-1:0] pc
);

    localparam logic [BUS_WIDTH-1:0] ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    // Increment wraps naturally at 2^BUS_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with IR handshake, branch flush and halt
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE  = HALT_OPCODE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [BUS_WIDTH-1:0] instr_address,
    input  logic [BUS_WIDTH-1:0] instruction,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [BUS_WIDTH-1:0] ir_pc,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    input  logic                 branch_en,
    input  logic [BUS_WIDTH-1:0] branch_target,
    output logic                 halted
);

    fetch_state_t         state;
    fetch_state_t         next_state;
    logic [BUS_WIDTH-1:0] pc;
    logic                 slot_free;
    logic                 capture;
    logic                 pc_load;
    logic                 clear_valid;
    logic                 is_halt_op;

    assign slot_free     = !ir_valid || ir_ready;
    assign is_halt_op    = (instruction[BUS_WIDTH-1 -: OPCODE_W] == HALT_OPCODE);
    assign instr_address = pc;

    pc_reg #(
        .BUS_WIDTH    (BUS_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .target (branch_target),
        .inc    (capture),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                pc_load = branch_en;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // A branch flushes even an instruction decode is accepting now.
                if (branch_en) begin
                    pc_load     = 1'b1;
                    clear_valid = 1'b1;
                end else if (slot_free) begin
                    capture = 1'b1;
                    if (is_halt_op) begin
                        next_state = HALT;
                    end
                end
            end
            HALT: begin
                clear_valid = ir_ready;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (capture) begin
                ir       <= instruction;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end else if (clear_valid) begin
                ir_valid <= 1'b0;
            end
            halted <= (next_state == HALT);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr_address;
    logic [15:0] instruction;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halted;

    int errors = 0;
    int checks = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_ir_pc;
    logic        m_valid;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .instr_address (instr_address),
        .instruction   (instruction),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory image: address 7 holds the halt word, the rest never decode as halt.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0007) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    assign instruction = mem_word(instr_address);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [15:0] w;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 16'h0000; m_ir = 16'h0000;
            m_ir_pc = 16'h0000; m_valid = 1'b0;
        end else if (m_mode == M_IDLE) begin
            if (branch_en) m_pc = branch_target;
            if (start) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (branch_en) begin
                m_pc = branch_target;
                m_valid = 1'b0;
            end else if (!m_valid || ir_ready) begin
                w = mem_word(m_pc);
                m_ir = w;
                m_ir_pc = m_pc;
                m_valid = 1'b1;
                m_pc = m_pc + 16'd1;
                if (w[15:12] == 4'hF) m_mode = M_HALT;
            end
        end else begin
            if (ir_ready) m_valid = 1'b0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("m_addr", instr_address, m_pc);
        check("m_valid", {15'd0, ir_valid}, {15'd0, m_valid});
        check("m_ir", ir, m_ir);
        check("m_ir_pc", ir_pc, m_ir_pc);
        check("m_halted", {15'd0, halted}, {15'd0, m_mode == M_HALT});
    endtask

    logic [15:0] wrap_seq [4];
    logic [15:0] wrap_exp [4];
    int          wrap_n;

    initial begin
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

        // Reset state
        step(); step();
        check("rst_addr", instr_address, 16'h0000);
        check("rst_valid", {15'd0, ir_valid}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        check("rst_ir", ir, 16'h0000);

        // Straight-line fetch
        rst = 1'b0; start = 1'b1; ir_ready = 1'b1;
        step();
        check("sl_valid_n", {15'd0, ir_valid}, 16'h0000);
        start = 1'b0;
        step();
        check("sl_valid_n1", {15'd0, ir_valid}, 16'h0001);
        check("sl_pc0", ir_pc, 16'h0000);
        check("sl_ir0", ir, 16'h1000);
        step(); check("sl_pc1", ir_pc, 16'h0001);
        step(); check("sl_pc2", ir_pc, 16'h0002);
        step(); check("sl_pc3", ir_pc, 16'h0003);

        // Stall for 4 cycles
        ir_ready = 1'b0;
        repeat (4) begin
            step();
            check("st_pc", ir_pc, 16'h0003);
            check("st_addr", instr_address, 16'h0004);
            check("st_ir", ir, 16'h1003);
        end
        ir_ready = 1'b1;
        step(); check("st_rel", ir_pc, 16'h0004);
        step(); check("st_pc5", ir_pc, 16'h0005);

        // Branch with bubble
        branch_en = 1'b1; branch_target = 16'h0010;
        step(); check("br_flush", {15'd0, ir_valid}, 16'h0000);
        branch_en = 1'b0;
        step();
        check("br_pc", ir_pc, 16'h0010);
        check("br_ir", ir, 16'h1010);

        // Branch coincident with a stall
        ir_ready = 1'b0;
        step(); check("bs_hold", ir_pc, 16'h0010);
        branch_en = 1'b1; branch_target = 16'h0020;
        step(); check("bs_flush", {15'd0, ir_valid}, 16'h0000);
        branch_en = 1'b0; ir_ready = 1'b1;
        step(); check("bs_pc", ir_pc, 16'h0020);

        // Halt at address 7
        branch_en = 1'b1; branch_target = 16'h0006;
        step();
        branch_en = 1'b0;
        step(); check("h_pc6", ir_pc, 16'h0006);
        ir_ready = 1'b0;
        step();
        ir_ready = 1'b1;
        step();
        check("h_ir", ir, 16'hF000);
        check("h_irpc", ir_pc, 16'h0007);
        check("h_halted", {15'd0, halted}, 16'h0001);
        check("h_valid", {15'd0, ir_valid}, 16'h0001);
        start = 1'b1; branch_en = 1'b1; branch_target = 16'h0030;
        repeat (3) begin
            step();
            check("h_valid0", {15'd0, ir_valid}, 16'h0000);
            check("h_addr", instr_address, 16'h0008);
        end
        start = 1'b0; branch_en = 1'b0;
        rst = 1'b1;
        step();
        check("h_rst_addr", instr_address, 16'h0000);
        check("h_rst_halted", {15'd0, halted}, 16'h0000);

        // Wrap-around
        rst = 1'b0; start = 1'b1; branch_en = 1'b1; branch_target = 16'hFFFE;
        step(); check("w_addr", instr_address, 16'hFFFE);
        start = 1'b0; branch_en = 1'b0;
        wrap_n = 0;
        for (int i = 0; i < 12 && wrap_n < 4; i++) begin
            step();
            if (ir_valid) begin
                wrap_seq[wrap_n] = ir_pc;
                wrap_n++;
            end
        end
        check("w_count", 16'(wrap_n), 16'd4);
        for (int i = 0; i < wrap_n; i++) check("w_seq", wrap_seq[i], wrap_exp[i]);

        // Reset during a stall
        ir_ready = 1'b0;
        step();
        check("rm_valid", {15'd0, ir_valid}, 16'h0001);
        rst = 1'b1;
        step();
        check("rm_addr", instr_address, 16'h0000);
        check("rm_valid0", {15'd0, ir_valid}, 16'h0000);
        check("rm_irpc", ir_pc, 16'h0000);
        rst = 1'b0; ir_ready = 1'b1;
        repeat (3) begin
            step();
            check("rm_idle", {15'd0, ir_valid}, 16'h0000);
        end
        start = 1'b1; step(); start = 1'b0; step();
        check("rm_resume", ir_pc, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(99) < 2);
            start         = ($urandom_range(99) < 15);
            ir_ready      = ($urandom_range(99) < 70);
            branch_en     = ($urandom_range(99) < 10);
            branch_target = ($urandom_range(3) == 0) ? 16'($urandom_range(12))
                                                     : 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the rudimentary processor; owns the program counter and drives the address input of the combinational instruction memory (i_mem).
- Captures the returned instruction into an instruction register and hands it to decode over a valid/ready handshake.
- Handles branch redirects (with flush), stalls from decode back-pressure, PC wrap-around and a halt opcode.

Parameters:
- BUS_WIDTH, 16, width of address, instruction and PC.
- RESET_VECTOR, 16'h0000, PC value after reset.
- HALT_OPCODE, 4'hF, value of instruction[BUS_WIDTH-1 -: 4] that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from current PC; honoured only in IDLE.
- instr_address  out  BUS_WIDTH  address to i_mem; equals PC register.
- instruction  in  BUS_WIDTH  i_mem read data; combinational from instr_address, sampled same cycle.
- ir  out  BUS_WIDTH  registered instruction to decode.
- ir_pc  out  BUS_WIDTH  address the instruction in ir was fetched from.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- branch_en  in  1  redirect request, one-cycle pulse.
- branch_target  in  BUS_WIDTH  new PC when branch_en=1.
- halted  out  1  high while in HALT state.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_VECTOR, ir=0, ir_pc=0, ir_valid=0, halted=0. rst overrides every other input, including mid-fetch and in HALT.
- FSM states: IDLE, RUN, HALT. Encoding is registered; one-hot or binary is acceptable.
- IDLE:
  - start=1 -> RUN next cycle.
  - branch_en=1 -> pc<=branch_target, stay IDLE (sets the entry point).
  - If both are asserted, both take effect: the pc is loaded and the state moves to RUN.
  - No captures occur in IDLE.
- RUN, defined terms:
  - slot_free = !ir_valid || ir_ready.
  - capture = slot_free && !branch_en.
- RUN, branch_en=1 (highest priority):
  - pc<=branch_target, ir_valid<=0 (flush, including an instruction being accepted this cycle).
  - No capture, stay RUN.
  - This gives a one-cycle bubble: first target instruction valid 2 edges after the branch pulse.
- RUN, capture (takes effect at the edge):
  - ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - PC arithmetic is modulo 2^BUS_WIDTH (16'hFFFF -> 16'h0000, no flag).
  - If the captured instruction's top 4 bits equal HALT_OPCODE, state<=HALT. The halt instruction itself is presented to decode.
- RUN, stall (!slot_free and no branch): pc, ir, ir_pc, ir_valid hold. instr_address stays stable.
- RUN, ir_valid=1 && ir_ready=1 && capture: back-to-back; ir is replaced by the next instruction with ir_valid staying 1. Sustained throughput is 1 instruction/cycle.
- RUN, ir_valid=1 && ir_ready=1 && !capture (branch only): ir_valid<=0.
- HALT:
  - halted=1 (registered, asserted the cycle after entry). pc frozen at halt address+1.
  - ir_valid clears on ir_ready=1 and never re-asserts.
  - start and branch_en are ignored. Exit only via rst.
- Latency: start at edge N -> RUN after N. First capture at edge N+1, so ir_valid is high after N+1 with ir_pc=RESET_VECTOR.
- instr_address is purely registered (=pc). There is no combinational path from any input to instr_address.

Decomposition:
- Shared package cpu_pkg:
  - Typedef fetch_state_t {IDLE, RUN, HALT}.
  - Localparam OPCODE_W=4.
  - HALT_OPCODE default constant, shared with the decoder.
- One natural sub-module: pc_reg. It holds the PC with priority load (reset > branch > increment) and modulo wrap.
- FSM and IR pipeline register stay in fetch_ctrl.
- i_mem is instantiated outside, at processor top.

Test Plan:
- Straight-line: i_mem preloaded with 16'h1000+addr; rst, start, ir_ready=1.
  - ir_valid rises 2 edges after start.
  - ir_pc steps 0,1,2,... each cycle; ir=16'h1000,16'h1001,...
- Stall: with ir_valid=1 at ir_pc=3, hold ir_ready=0 for 4 cycles.
  - ir, ir_pc=3 and instr_address=4 stay constant.
  - On release, ir_pc=4 next cycle, with no skipped or duplicated addresses.
- Branch: branch_en pulse with target 16'h0010 while ir_pc=5.
  - Next cycle ir_valid=0.
  - The following cycle ir_pc=16'h0010, ir=16'h1010.
  - Branch coincident with a stall also flushes.
- Halt: word at address 7 = 16'hF000.
  - ir=16'hF000 presented with ir_pc=7, then halted=1.
  - After acceptance, ir_valid=0 permanently; start and branch_en have no effect.
  - rst returns the block to IDLE with pc=0.
- Wrap: branch to 16'hFFFE, ir_ready=1.
  - Captured ir_pc sequence FFFE, FFFF, 0000, 0001.
- Reset mid-run: assert rst during a stall with ir_valid=1.
  - Next cycle all outputs are at reset values and state is IDLE.
  - start is then required to resume.
